// File: rtl/led_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | led_seq_pkg: shared types and constants for the LED pattern sequencer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package led_seq_pkg;

    typedef enum logic [1:0] {
        ROTL   = 2'd0,
        ROTR   = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int unsigned LED_RESET_PATTERN = 1;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// +-----------------------------------------------------------------------+
// | led_tick_gen: programmable step prescaler with pause                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module led_tick_gen #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] speed_i,
    input  logic       pause_i,
    output logic       tick_o
);

    localparam int unsigned CW = $clog2(TICK_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] w_shifted;
    logic [CW-1:0] w_period;
    logic [CW-1:0] w_last;
    logic          w_tick;

    // Comparing with >= lets a speed increase that overtakes cnt still fire a tick and wrap.
    assign w_shifted = CW'(TICK_DIV) >> speed_i;
    assign w_period  = (w_shifted == '0) ? CW'(1) : w_shifted;
    assign w_last    = w_period - 1'b1;
    assign w_tick    = ~rst & ~pause_i & (cnt_q >= w_last);
    assign tick_o    = w_tick;

    always_comb begin
        cnt_d = cnt_q;
        if (!pause_i) begin
            cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// +-----------------------------------------------------------------------+
// | led_pattern_sequencer: 4-mode LED pattern engine with request arbiter |
// | Optional PWM dimming via `define LED_PWM_DIM_EN.  Rev 1.0             |
// +-----------------------------------------------------------------------+
`default_nettype none

module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_valid,
    input  logic [1:0]          mode_data,
    output logic                mode_ready,
    input  logic                btn_next,
    input  logic [2:0]          speed,
    input  logic                pause,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0] bright,
`endif
    output logic [WIDTH-1:0]    led,
    output logic [1:0]          mode,
    output logic                tick
);

    if (WIDTH < 2) begin : g_bad_width
        $error("led_pattern_sequencer: WIDTH must be at least 2");
    end
    if (PWM_BITS < 1) begin : g_bad_pwm
        $error("led_pattern_sequencer: PWM_BITS must be at least 1");
    end

    mode_e            mode_q,   mode_d;
    mode_e            target_q, target_d;
    dir_e             dir_q,    dir_d;
    logic             pend_q,   pend_d;
    logic [WIDTH-1:0] led_q,    led_d;
    logic             w_tick;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .speed_i (speed),
        .pause_i (pause),
        .tick_o  (w_tick)
    );

    assign tick       = w_tick;
    assign mode       = mode_q;
    assign mode_ready = ~pend_q;

    always_comb begin
        mode_d   = mode_q;
        target_d = target_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        led_d    = led_q;

        if (w_tick) begin
            if (pend_q) begin
                mode_d = target_q;
                pend_d = 1'b0;
                dir_d  = DIR_LEFT;
                led_d  = (target_q == BLINK) ? '1 : WIDTH'(LED_RESET_PATTERN);
            end else begin
                case (mode_q)
                    ROTL:   led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    ROTR:   led_d = {led_q[0], led_q[WIDTH-1:1]};
                    BOUNCE: begin
                        // Turn around on the end bit so each end is shown only once.
                        if (dir_q == DIR_LEFT) begin
                            if (led_q[WIDTH-1]) begin
                                dir_d = DIR_RIGHT;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_d = DIR_LEFT;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    BLINK:   led_d = ~led_q;
                    default: led_d = led_q;
                endcase
            end
        end

        // Only an empty slot takes a request; the control port has priority over the button.
        if (!pend_q) begin
            if (mode_valid) begin
                pend_d   = 1'b1;
                target_d = mode_e'(mode_data);
            end else if (btn_next) begin
                pend_d   = 1'b1;
                target_d = next_mode(mode_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= ROTL;
            target_q <= ROTL;
            dir_q    <= DIR_LEFT;
            pend_q   <= 1'b0;
            led_q    <= WIDTH'(LED_RESET_PATTERN);
        end else begin
            mode_q   <= mode_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            led_q    <= led_d;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pcnt_q;
    logic                w_gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    assign w_gate = (pcnt_q < bright) | (&bright);
    assign led    = led_q & {WIDTH{w_gate}};
`else
    assign led = led_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_led_pattern_sequencer: directed table, bounce sequence, random run |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_valid;
    logic [1:0]  mode_data;
    logic        mode_ready;
    logic        btn_next;
    logic [2:0]  speed;
    logic        pause;
    logic [15:0] led;
    logic [1:0]  mode;
    logic        tick;
`ifdef LED_PWM_DIM_EN
    logic [3:0]  bright;
`endif

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .WIDTH    (16),
        .TICK_DIV (8),
        .PWM_BITS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_valid (mode_valid),
        .mode_data  (mode_data),
        .mode_ready (mode_ready),
        .btn_next   (btn_next),
        .speed      (speed),
        .pause      (pause),
`ifdef LED_PWM_DIM_EN
        .bright     (bright),
`endif
        .led        (led),
        .mode       (mode),
        .tick       (tick)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pattern state is just (mode, steps since reload).
    bit m_valid = 1'b0;
    int m_mode, m_step, m_cnt, m_target;
    bit m_pend;

    function automatic logic [15:0] exp_led(input int md, input int s);
        logic [15:0] one;
        int t, p;
        one = 16'd1;
        case (md)
            0: return one << (s % 16);
            1: return one << ((16 - (s % 16)) % 16);
            2: begin
                t = s % 30;
                p = (t <= 15) ? t : 30 - t;
                return one << p;
            end
            default: return ((s % 2) == 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic bit exp_tick();
        int p;
        p = 8 >> speed;
        if (p < 1) p = 1;
        return !rst && !pause && (m_cnt >= p - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit t, old_pend;
        int old_mode;
        if (rst) begin
            m_valid = 1'b1;
            m_mode  = 0;
            m_step  = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
        end else if (m_valid) begin
            t        = exp_tick();
            old_pend = m_pend;
            old_mode = m_mode;
            if (t) begin
                if (m_pend) begin
                    m_mode = m_target;
                    m_pend = 1'b0;
                    m_step = 0;
                end else begin
                    m_step++;
                end
            end
            if (!pause) m_cnt = t ? 0 : m_cnt + 1;
            if (!old_pend) begin
                if (mode_valid) begin
                    m_pend   = 1'b1;
                    m_target = int'(mode_data);
                end else if (btn_next) begin
                    m_pend   = 1'b1;
                    m_target = (old_mode + 1) % 4;
                end
            end
        end
    endtask

    // One clock: compare against the model mid-cycle, then advance both on the edge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid) begin
            check("model_led",   32'(led),        32'(exp_led(m_mode, m_step)));
            check("model_mode",  32'(mode),       32'(m_mode));
            check("model_ready", 32'(mode_ready), 32'(!m_pend));
            check("model_tick",  32'(tick),       32'(exp_tick()));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          mv;
        logic [1:0]  md;
        bit          btn;
        logic [2:0]  spd;
        bit          pse;
        int          n;
        logic [15:0] e_led;
        logic [1:0]  e_mode;
        bit          e_rdy;
    } vec_t;

    vec_t tbl[17];
    logic [15:0] bq[$];

    initial begin
`ifdef LED_PWM_DIM_EN
        bright = 4'hF;
`endif
        rst = 1'b1; mode_valid = 1'b0; mode_data = 2'd0;
        btn_next = 1'b0; speed = 3'd0; pause = 1'b0;

        //         rst  mv  md  btn spd pse n  led       mode rdy
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 2, 16'h0001, 0, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 8, 16'h0002, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 8, 16'h0004, 0, 1};
        tbl[3]  = '{0, 1, 3, 0, 0, 0, 1, 16'h0004, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 6, 16'h0004, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 3, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 8, 16'h0000, 3, 1};
        tbl[7]  = '{0, 1, 1, 1, 0, 0, 1, 16'h0000, 3, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 7, 16'h0001, 1, 1};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 1, 16'h0001, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 7, 16'h0001, 2, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 8, 16'h0002, 2, 1};
        tbl[12] = '{0, 0, 0, 1, 0, 0, 1, 16'h0002, 2, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 1};
        tbl[14] = '{0, 0, 0, 0, 3, 0, 1, 16'h0002, 0, 1};
        tbl[15] = '{0, 0, 0, 0, 3, 1, 5, 16'h0002, 0, 1};
        tbl[16] = '{0, 0, 0, 0, 3, 0, 3, 16'h0010, 0, 1};

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; mode_valid = tbl[i].mv; mode_data = tbl[i].md;
            btn_next = tbl[i].btn; speed = tbl[i].spd; pause = tbl[i].pse;
            repeat (tbl[i].n) cyc();
            check($sformatf("vec%0d_led", i),   32'(led),        32'(tbl[i].e_led));
            check($sformatf("vec%0d_mode", i),  32'(mode),       32'(tbl[i].e_mode));
            check($sformatf("vec%0d_ready", i), 32'(mode_ready), 32'(tbl[i].e_rdy));
        end
        rst = 1'b0; mode_valid = 1'b0; btn_next = 1'b0; pause = 1'b0;

        // Bounce at one step per cycle: both ends appear exactly once.
        for (int i = 0; i < 16; i++) bq.push_back(16'd1 << i);
        for (int i = 14; i >= 0; i--) bq.push_back(16'd1 << i);
        bq.push_back(16'h0002);
        speed = 3'd3;
        mode_valid = 1'b1; mode_data = 2'd2;
        cyc();
        mode_valid = 1'b0;
        cyc();
        check("bounce_mode", 32'(mode), 32'd2);
        check("bounce_0", 32'(led), 32'(bq[0]));
        for (int k = 1; k < 32; k++) begin
            cyc();
            check($sformatf("bounce_%0d", k), 32'(led), 32'(bq[k]));
        end

        // Randomized traffic against the model.
        speed = 3'd0;
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom % 400) == 0;
            mode_valid = ($urandom % 6) == 0;
            mode_data  = 2'($urandom);
            btn_next   = ($urandom % 10) == 0;
            pause      = ($urandom % 8) == 0;
            if (($urandom % 50) == 0) speed = 3'($urandom_range(0, 4));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
